// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and a 64 KiB byte-addressed data memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two back-to-back cycles.
module lsu_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic [15:0] o_dmem_addr,
    output logic [31:0] o_dmem_data,
    output logic [3:0]  o_dmem_wren,
    input  logic [31:0] i_dmem_q
);

    logic [1:0] k;
    logic [4:0] sh_lo;
    logic [3:0] size_mask;
    logic [3:0] wren_lo;
    logic       legal;
    logic       fault;

    assign k       = i_addr[1:0];
    assign sh_lo   = {k, 3'b000};
    assign wren_lo = size_mask << k;

    always_comb begin
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~i_we;
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'h0, raw[7:0]};
            3'b101:  r = {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_EN
    typedef enum logic {IDLE, SECOND} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        crossing;
    logic [1:0]  nk;
    logic [1:0]  over;
    logic [4:0]  sh_hi;
    logic [3:0]  wren_hi;

    assign crossing = ((i_funct3[1:0] == 2'b01) && (k == 2'd3)) ||
                      ((i_funct3[1:0] == 2'b10) && (k != 2'd0));
    assign fault    = (i_addr[31:16] != 16'h0) || !legal ||
                      (crossing && (i_addr[15:2] == 14'h3FFF));
    // bytes spilling into the upper word: k+s-4, which is 1 for a halfword and k for a word
    assign over     = (i_funct3[1:0] == 2'b01) ? 2'd1 : k;
    assign wren_hi  = ~(4'b1111 << over);
    assign nk       = 2'd0 - k;
    assign sh_hi    = {nk, 3'b000};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end
`else
    logic natural;
    logic unused_clk;

    assign unused_clk = i_clk;
    assign natural    = (k & size_mask[2:1]) == 2'b00;
    assign fault      = (i_addr[31:16] != 16'h0) || !legal || !natural;
`endif

    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_fault     = 1'b0;
        o_rdata     = '0;
        o_dmem_addr = '0;
        o_dmem_data = '0;
        o_dmem_wren = '0;
`ifdef LSU_MISALIGN_EN
        state_d     = state_q;
        hold_d      = hold_q;
`endif
        // outputs are combinational, so hold them at reset values while reset is low
        if (i_reset) begin
`ifdef LSU_MISALIGN_EN
            if (state_q == SECOND) begin
                state_d = IDLE;
                if (i_req) begin
                    o_done      = 1'b1;
                    o_dmem_addr = {i_addr[15:2] + 14'd1, 2'b00};
                    if (i_we) begin
                        o_dmem_wren = wren_hi;
                        o_dmem_data = i_wdata >> sh_hi;
                    end else begin
                        o_rdata = extend(hold_q | (i_dmem_q << sh_hi), i_funct3);
                    end
                end
            end else
`endif
            if (i_req) begin
                o_dmem_addr = {i_addr[15:2], 2'b00};
                if (fault) begin
                    o_done  = 1'b1;
                    o_fault = 1'b1;
                end
`ifdef LSU_MISALIGN_EN
                else if (crossing) begin
                    o_busy  = 1'b1;
                    state_d = SECOND;
                    if (i_we) begin
                        o_dmem_wren = wren_lo;
                        o_dmem_data = i_wdata << sh_lo;
                    end else begin
                        hold_d = i_dmem_q >> sh_lo;
                    end
                end
`endif
                else begin
                    o_done = 1'b1;
                    if (i_we) begin
                        o_dmem_wren = wren_lo;
                        o_dmem_data = i_wdata << sh_lo;
                    end else begin
                        o_rdata = extend(i_dmem_q >> sh_lo, i_funct3);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory plus a byte-level reference model.
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset, i_req, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata, o_rdata, o_dmem_data, i_dmem_q;
    logic        o_busy, o_done, o_fault;
    logic [15:0] o_dmem_addr;
    logic [3:0]  o_dmem_wren;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 i_clk = ~i_clk;

    lsu_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
        .o_dmem_addr(o_dmem_addr), .o_dmem_data(o_dmem_data), .o_dmem_wren(o_dmem_wren),
        .i_dmem_q(i_dmem_q)
    );

    assign i_dmem_q = {mem[o_dmem_addr + 16'd3], mem[o_dmem_addr + 16'd2],
                       mem[o_dmem_addr + 16'd1], mem[o_dmem_addr]};

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + 11);
        forever begin
            @(posedge i_clk);
            for (int b = 0; b < 4; b++)
                if (o_dmem_wren[b]) mem[o_dmem_addr + 16'(b)] <= o_dmem_data[8*b +: 8];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] a);
        int s = 1 << f3[1:0];
        logic [31:0] v = '0;
        for (int i = 0; i < s; i++) v = v | (32'(ref_mem[a + 16'(i)]) << (8 * i));
        if (!f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8 * s));
        return v;
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd);
        int s = 1 << f3[1:0];
        for (int i = 0; i < s; i++) ref_mem[a + 16'(i)] = wd[8*i +: 8];
    endfunction

    function automatic logic [3:0] exp_wren(input int k, input int s);
        logic [3:0] w = '0;
        for (int b = 0; b < 4; b++) if (b >= k && b < k + s) w[b] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    // Drives one request from a negedge until done (bounded), collecting observations.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic flt, output logic [31:0] rd,
                          output int cyc, output logic gd, output logic [3:0] w0,
                          output logic [15:0] a0, output logic [31:0] d0, output logic b0);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        flt = 1'b0; rd = '0; cyc = 0; gd = 1'b0; w0 = '0; a0 = '0; d0 = '0; b0 = 1'b0;
        while (!gd && cyc < 4) begin
            #1;
            if (cyc == 0) begin
                w0 = o_dmem_wren; a0 = o_dmem_addr; d0 = o_dmem_data; b0 = o_busy;
            end
            if (o_done) begin
                gd = 1'b1; flt = o_fault; rd = o_rdata;
            end
            cyc++;
            @(negedge i_clk);
        end
        i_req = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0100; i_wdata = 32'hA5A5_5A5A;
        repeat (2) @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_busy, o_done, o_fault, o_rdata, o_dmem_addr, o_dmem_data, o_dmem_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b fault=%b rdata=%h addr=%h data=%h wren=%b want all zero",
                     o_busy, o_done, o_fault, o_rdata, o_dmem_addr, o_dmem_data, o_dmem_wren);
        end
        @(negedge i_clk);
        i_req = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (mem_word(16'h0100) !== ref_word(16'h0100)) begin
            n_fail++;
            $display("FAIL reset_no_write: got %h want %h", mem_word(16'h0100), ref_word(16'h0100));
        end
    endtask

    task automatic test_aligned();
        logic flt, gd, b0; logic [31:0] rd, d0; int cyc; logic [3:0] w0; logic [15:0] a0;
        access(1'b1, 3'b010, 32'h0100, 32'hDEAD_BEEF, flt, rd, cyc, gd, w0, a0, d0, b0);
        ref_store(3'b010, 16'h0100, 32'hDEAD_BEEF);
        n_checks++;
        if ({gd, flt, b0} !== 3'b100 || cyc != 1) begin
            n_fail++; $display("FAIL sw_handshake: got done=%b fault=%b busy=%b cycles=%0d want 1 0 0 1", gd, flt, b0, cyc);
        end
        n_checks++;
        if (w0 !== 4'b1111 || a0 !== 16'h0100 || d0 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_mem_side: got wren=%b addr=%h data=%h want 1111 0100 deadbeef", w0, a0, d0);
        end
        access(1'b0, 3'b010, 32'h0100, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || !gd || b0 !== 1'b0 || cyc != 1 || w0 !== 4'b0000) begin
            n_fail++; $display("FAIL lw_aligned: got rdata=%h done=%b busy=%b wren=%b want deadbeef 1 0 0000", rd, gd, b0, w0);
        end
    endtask

    task automatic test_extend();
        logic flt, gd, b0; logic [31:0] rd, d0; int cyc; logic [3:0] w0; logic [15:0] a0;
        logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] adr  [3] = '{32'h0202, 32'h0203, 32'h0200};
        logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01};
        access(1'b1, 3'b010, 32'h0200, 32'h80FF_7F01, flt, rd, cyc, gd, w0, a0, d0, b0);
        ref_store(3'b010, 16'h0200, 32'h80FF_7F01);
        for (int i = 0; i < 3; i++) begin
            access(1'b0, f3s[i], adr[i], 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
            n_checks++;
            if (rd !== want[i] || rd !== ref_load(f3s[i], adr[i][15:0]) || flt || !gd) begin
                n_fail++; $display("FAIL extend_%0d: got %h want %h", i, rd, want[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic flt, gd, b0; logic [31:0] rd, d0; int cyc; logic [3:0] w0; logic [15:0] a0;
        logic        wes [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [5] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b110};
        logic [31:0] adr [5] = '{32'h0001_0000, 32'h0000_FFFD, 32'h0700, 32'h0704, 32'h0708};
        for (int i = 0; i < 5; i++) begin
            access(wes[i], f3s[i], adr[i], $urandom, flt, rd, cyc, gd, w0, a0, d0, b0);
            n_checks++;
            if (!flt || !gd || cyc != 1 || w0 !== 4'b0000 || b0 !== 1'b0) begin
                n_fail++; $display("FAIL fault_%0d: got fault=%b done=%b cycles=%0d wren=%b want 1 1 1 0000", i, flt, gd, cyc, w0);
            end
            n_checks++;
            if (mem_word({adr[i][15:2], 2'b00}) !== ref_word({adr[i][15:2], 2'b00})) begin
                n_fail++; $display("FAIL fault_nowrite_%0d: got %h want %h",
                                   i, mem_word({adr[i][15:2], 2'b00}), ref_word({adr[i][15:2], 2'b00}));
            end
        end
    endtask

`ifdef LSU_MISALIGN_EN
    task automatic test_misalign();
        logic flt, gd, b0; logic [31:0] rd, d0, wd; int cyc; logic [3:0] w0; logic [15:0] a0;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0303; i_wdata = 32'h1122_3344;
        #1;
        n_checks++;
        if (o_dmem_addr !== 16'h0300 || o_dmem_wren !== 4'b1000 || o_dmem_data[31:24] !== 8'h44 || !o_busy || o_done) begin
            n_fail++; $display("FAIL cross_sw_c1: got addr=%h wren=%b data=%h busy=%b done=%b want 0300 1000 44xxxxxx 1 0",
                               o_dmem_addr, o_dmem_wren, o_dmem_data, o_busy, o_done);
        end
        @(negedge i_clk); #1;
        n_checks++;
        if (o_dmem_addr !== 16'h0304 || o_dmem_wren !== 4'b0111 || o_dmem_data[23:0] !== 24'h112233 || !o_done || o_busy) begin
            n_fail++; $display("FAIL cross_sw_c2: got addr=%h wren=%b data=%h done=%b busy=%b want 0304 0111 xx112233 1 0",
                               o_dmem_addr, o_dmem_wren, o_dmem_data, o_done, o_busy);
        end
        @(negedge i_clk);
        i_req = 1'b0;
        ref_store(3'b010, 16'h0303, 32'h1122_3344);
        access(1'b0, 3'b010, 32'h0303, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (rd !== 32'h1122_3344 || cyc != 2 || !gd || flt || b0 !== 1'b1) begin
            n_fail++; $display("FAIL cross_lw: got rdata=%h cycles=%0d busy0=%b want 11223344 2 1", rd, cyc, b0);
        end
        access(1'b0, 3'b001, 32'h0311, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (rd !== ref_load(3'b001, 16'h0311) || cyc != 1 || flt) begin
            n_fail++; $display("FAIL lh_k1: got rdata=%h cycles=%0d want %h 1", rd, cyc, ref_load(3'b001, 16'h0311));
        end

        // flush: drop request during the second half
        wd = $urandom;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0501; i_wdata = wd;
        #1;
        n_checks++;
        if (o_dmem_wren !== 4'b1110 || !o_busy) begin
            n_fail++; $display("FAIL flush_c1: got wren=%b busy=%b want 1110 1", o_dmem_wren, o_busy);
        end
        @(negedge i_clk);
        i_req = 1'b0;
        #1;
        n_checks++;
        if (o_done !== 1'b0 || o_dmem_wren !== 4'b0000) begin
            n_fail++; $display("FAIL flush_c2: got done=%b wren=%b want 0 0000", o_done, o_dmem_wren);
        end
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) ref_mem[16'h0501 + 16'(i)] = wd[8*i +: 8];
        n_checks++;
        if (mem_word(16'h0500) !== ref_word(16'h0500) || mem_word(16'h0504) !== ref_word(16'h0504)) begin
            n_fail++; $display("FAIL flush_mem: got %h %h want %h %h", mem_word(16'h0500), mem_word(16'h0504),
                               ref_word(16'h0500), ref_word(16'h0504));
        end
        access(1'b0, 3'b010, 32'h0500, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (rd !== ref_word(16'h0500) || cyc != 1) begin
            n_fail++; $display("FAIL flush_idle: got rdata=%h cycles=%0d want %h 1", rd, cyc, ref_word(16'h0500));
        end

        // reset asserted during the second half
        wd = $urandom;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0501; i_wdata = wd;
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_fault, o_rdata, o_dmem_addr, o_dmem_data, o_dmem_wren} !== '0) begin
            n_fail++; $display("FAIL second_reset_outputs: got busy=%b done=%b wren=%b addr=%h data=%h want all zero",
                               o_busy, o_done, o_dmem_wren, o_dmem_addr, o_dmem_data);
        end
        @(negedge i_clk);
        i_req = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        for (int i = 0; i < 3; i++) ref_mem[16'h0501 + 16'(i)] = wd[8*i +: 8];
        n_checks++;
        if (mem_word(16'h0500) !== ref_word(16'h0500) || mem_word(16'h0504) !== ref_word(16'h0504)) begin
            n_fail++; $display("FAIL second_reset_mem: got %h %h want %h %h", mem_word(16'h0500), mem_word(16'h0504),
                               ref_word(16'h0500), ref_word(16'h0504));
        end
        access(1'b0, 3'b010, 32'h0504, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (rd !== ref_word(16'h0504) || cyc != 1) begin
            n_fail++; $display("FAIL second_reset_idle: got rdata=%h cycles=%0d want %h 1", rd, cyc, ref_word(16'h0504));
        end
    endtask
`else
    task automatic test_misalign();
        logic flt, gd, b0; logic [31:0] rd, d0; int cyc; logic [3:0] w0; logic [15:0] a0;
        access(1'b0, 3'b001, 32'h0401, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (!flt || !gd || cyc != 1 || w0 !== 4'b0000 || b0 !== 1'b0) begin
            n_fail++; $display("FAIL lh_misaligned: got fault=%b done=%b cycles=%0d wren=%b want 1 1 1 0000", flt, gd, cyc, w0);
        end
        access(1'b1, 3'b010, 32'h0402, $urandom, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (!flt || cyc != 1 || w0 !== 4'b0000 || mem_word(16'h0400) !== ref_word(16'h0400)) begin
            n_fail++; $display("FAIL sw_misaligned: got fault=%b wren=%b mem=%h want 1 0000 %h", flt, w0, mem_word(16'h0400), ref_word(16'h0400));
        end
        access(1'b0, 3'b001, 32'h0402, 32'h0, flt, rd, cyc, gd, w0, a0, d0, b0);
        n_checks++;
        if (flt || rd !== ref_load(3'b001, 16'h0402)) begin
            n_fail++; $display("FAIL lh_natural: got fault=%b rdata=%h want 0 %h", flt, rd, ref_load(3'b001, 16'h0402));
        end
    endtask
`endif

    task automatic test_random();
        logic flt, gd, b0; logic [31:0] rd, d0, wd; int cyc; logic [3:0] w0; logic [15:0] a0;
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] f3;
        logic [15:0] a;
        logic we;
        int s, k, exp_cyc, bad;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            s  = 1 << f3[1:0];
            a  = 16'h0600 + 16'($urandom_range(0, 255));
`ifndef LSU_MISALIGN_EN
            a  = a - 16'(a % s);
`endif
            k  = a % 4;
            exp_cyc = (k + s > 4) ? 2 : 1;
            wd = $urandom;
            access(we, f3, {16'h0, a}, wd, flt, rd, cyc, gd, w0, a0, d0, b0);
            n_checks++;
            if (!gd || flt || cyc != exp_cyc) begin
                n_fail++; $display("FAIL rand_%0d_handshake: we=%b f3=%b addr=%h got done=%b fault=%b cycles=%0d want 1 0 %0d",
                                   n, we, f3, a, gd, flt, cyc, exp_cyc);
            end
            if (we) begin
                ref_store(f3, a, wd);
                n_checks++;
                if (w0 !== exp_wren(k, s)) begin
                    n_fail++; $display("FAIL rand_%0d_wren: addr=%h got %b want %b", n, a, w0, exp_wren(k, s));
                end
            end else begin
                n_checks++;
                if (rd !== ref_load(f3, a)) begin
                    n_fail++; $display("FAIL rand_%0d_load: f3=%b addr=%h got %h want %h", n, f3, a, rd, ref_load(f3, a));
                end
            end
        end
        bad = 0;
        for (int i = 16'h0600; i < 16'h0708; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rand_mem_image: got %0d differing bytes want 0", bad);
        end
    endtask

    initial begin
        i_reset = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 11);
        test_reset();
        test_aligned();
        test_extend();
        test_faults();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting between the MEM pipeline stage and the 64 KiB data memory. It drives the memory's byte-address, write-data and byte-enable inputs, and returns extended load data to writeback. Misaligned accesses that straddle a word boundary are optionally split into two back-to-back word accesses under FSM control, with a stall to the pipeline.

## Interface
- No parameters. Memory size is fixed at 64 KiB, byte addresses 0x0000–0xFFFF.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  MEM stage holds a valid load/store. Held with operands stable while o_busy=1.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- i_addr  in  32  effective byte address.
- i_wdata  in  32  store data (rs2).
- o_busy  out  1  stall the pipeline; the request is not finished this cycle.
- o_done  out  1  the access completes this cycle.
- o_fault  out  1  access fault this cycle: range, illegal width, or misalignment. Coincides with o_done.
- o_rdata  out  32  load result, sign- or zero-extended. Valid when o_done && !i_we.
- o_dmem_addr  out  16  word-aligned byte address to memory, bits [1:0]=00.
- o_dmem_data  out  32  lane-shifted write data.
- o_dmem_wren  out  4  byte write enables.
- i_dmem_q  in  32  memory read word, combinational from o_dmem_addr.

## Operation
- Offset k=i_addr[1:0]. Size s is 1, 2 or 4 bytes. A request is "crossing" when k+s>4. A request is "natural" when k mod s = 0.
- FSM states:
  - IDLE: the first or only access.
  - SECOND: the upper word of a crossing access.
- Fault check, done in IDLE with i_req=1. Any fault gives o_done=1, o_fault=1, wren=0000 and no state change. Fault conditions:
  - i_addr[31:16]≠0.
  - Illegal funct3 (011, 110, 111, or 100/101 with i_we=1).
  - Crossing access with i_addr[15:2]=0x3FFF (no wrap to 0x0000).
- Non-crossing access: completes in IDLE in one cycle with o_done=1 and o_busy=0.
  - Store: wren = ((1<<s)-1)<<k, data = i_wdata<<(8k).
  - Load: o_rdata = extend(i_dmem_q>>(8k)).
- Crossing access:
  - IDLE cycle: addr = {i_addr[15:2],00}, o_busy=1.
    - Store: wren = 4'b1111<<k truncated to the bytes of s, data = i_wdata<<(8k).
    - Load: capture i_dmem_q>>(8k) into hold register.
    - Next state SECOND.
  - SECOND cycle: addr += 4, o_done=1, next state IDLE.
    - Store: wren = (1<<(k+s-4))-1, data = i_wdata>>(8(4-k)).
    - Load: o_rdata = extend(hold | i_dmem_q<<(8(4-k))).
- Extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- i_req=0 in SECOND is a flush: return to IDLE, no second access, o_done=0. The first half of a store is already written; this is accepted.
- i_req=0 in IDLE: wren=0000, o_done=0, o_busy=0.

## Timing
- Reset values: state IDLE, hold register 0, o_busy=0, o_done=0, o_fault=0, o_rdata=0, o_dmem_wren=0000, o_dmem_addr=0, o_dmem_data=0.
- All memory-side outputs and o_rdata are combinational from state, request and i_dmem_q.
- Store bytes commit on the memory's next posedge.
- Latency:
  - Non-crossing access: 0 extra cycles.
  - Crossing access: 1 stall cycle, then done.
- Reset asserted mid-SECOND aborts immediately to IDLE. Any second-half write is suppressed.

## Configuration
- LSU_MISALIGN_EN defined: crossing accesses are split as above. Non-natural, non-crossing accesses (e.g. LH at k=1) complete in one cycle.
- LSU_MISALIGN_EN undefined: any non-natural access faults in IDLE with no write. The SECOND state and hold register are not built. o_busy is tied 0.

## Test plan
- SW 0xDEADBEEF at 0x0100, then LW 0x0100 -> wren=1111, addr 0x0100. Load returns 0xDEADBEEF, o_done=1, o_busy=0.
- Word 0x0200 = 0x80FF7F01. LB 0x0202 -> 0xFFFFFFFF. LBU 0x0203 -> 0x00000080. LH 0x0200 -> 0x00007F01.
- With macro: SW 0x11223344 at 0x0303 -> cycle 1: addr 0x0300, wren=1000, data[31:24]=0x44, busy=1. Cycle 2: addr 0x0304, wren=0111, data[23:0]=0x112233, done=1. LW 0x0303 then returns 0x11223344 after 1 stall.
- Without macro: LH 0x0401 -> o_fault=1, o_done=1, wren=0000 in a single cycle.
- Faults: LW 0x00010000, SW at 0xFFFD (with macro), and funct3=011 each give o_fault=1 with no memory write.
- Crossing SW at 0x0501: drop i_req in SECOND -> only 0x0500 bytes 1–3 written, 0x0504 unchanged, FSM back in IDLE. Repeat with reset low in SECOND -> same outcome, and all outputs at reset values.
